// File: rtl/rlbp_wb_ctrl.sv
// Wishbone classic slave controlling N_CH RLBP cores: per-channel control words, start/wait FSMs,
// sticky done/timeout status with W1C and a level interrupt. Optional per-channel timeout: RLBP_TIMEOUT_EN.
module rlbp_wb_ctrl #(
    parameter int N_CH   = 2,
    parameter int CTRL_W = 12,
    parameter int TO_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_adr_i,
    input  logic [31:0]              wbs_dat_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    output logic [N_CH*CTRL_W-1:0]   ch_ctrl,
    output logic [N_CH-1:0]          ch_start,
    input  logic [N_CH-1:0]          ch_done,
    output logic                     irq,
    output logic [2*N_CH-1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } ch_state_e;

    localparam logic [7:0] OFF_STATUS  = 8'h20;
    localparam logic [7:0] OFF_IRQ_EN  = 8'h24;
    localparam logic [7:0] OFF_CMD     = 8'h28;
    localparam logic [7:0] OFF_TIMEOUT = 8'h2C;

    // Bus handshake: a transfer is accepted when cyc&stb hit the 0x3xxxxxxx window while ack is low;
    // ack and read data are registered and presented for exactly the following cycle.
    logic       sel_win;
    logic       accept;
    logic       wr_en;
    logic [7:0] offset;

    assign sel_win = (wbs_adr_i[31:28] == 4'h3);
    assign offset  = wbs_adr_i[7:0];
    assign accept  = wbs_cyc_i & wbs_stb_i & sel_win & ~wbs_ack_o;
    assign wr_en   = accept & wbs_we_i & wbs_sel_i[0];

    logic                ack_q, ack_d;
    logic [31:0]         dat_q, dat_d;
    logic                irq_q, irq_d;
    logic [CTRL_W-1:0]   ctrl_q [N_CH];
    logic [CTRL_W-1:0]   ctrl_d [N_CH];
    logic [2*N_CH-1:0]   irq_en_q, irq_en_d;
    logic [N_CH-1:0]     done_q, done_d;
    logic [N_CH-1:0]     to_q, to_d;
    logic [N_CH-1:0]     done_set, to_set;
    logic [N_CH-1:0]     busy;
    ch_state_e           state_q [N_CH];
    ch_state_e           state_d [N_CH];
    logic [TO_W-1:0]     timeout_rd;
    logic [31:0]         rd_data;

`ifdef RLBP_TIMEOUT_EN
    logic [TO_W-1:0]     timeout_q, timeout_d;
    logic [TO_W-1:0]     cnt_q [N_CH];
    logic [TO_W-1:0]     cnt_d [N_CH];
    assign timeout_rd = timeout_q;
`else
    assign timeout_rd = '0;
`endif

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign busy[g]                      = (state_q[g] != ST_IDLE);
        assign ch_start[g]                  = (state_q[g] == ST_START);
        assign ch_ctrl[g*CTRL_W +: CTRL_W]  = ctrl_q[g];
        assign dbg_state[2*g +: 2]          = state_q[g];
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq       = irq_q;

    // Channel FSMs; a CMD bit only launches an idle channel, ch_done only matters in WAIT.
    always_comb begin
        done_set = '0;
        to_set   = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
`ifdef RLBP_TIMEOUT_EN
            cnt_d[i] = cnt_q[i];
`endif
            case (state_q[i])
                ST_IDLE: begin
                    if (wr_en && (offset == OFF_CMD) && wbs_dat_i[i]) state_d[i] = ST_START;
                end
                ST_START: begin
                    state_d[i] = ST_WAIT;
`ifdef RLBP_TIMEOUT_EN
                    cnt_d[i] = '0;
`endif
                end
                ST_WAIT: begin
                    if (ch_done[i]) begin
                        state_d[i]  = ST_IDLE;
                        done_set[i] = 1'b1;
                    end
`ifdef RLBP_TIMEOUT_EN
                    else if ((cnt_q[i] + TO_W'(1)) >= timeout_q) begin
                        state_d[i] = ST_IDLE;
                        to_set[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + TO_W'(1);
                    end
`endif
                end
                default: state_d[i] = ST_IDLE;
            endcase
        end
    end

    // Register writes; sticky bits are W1C with a same-cycle set taking priority.
    always_comb begin
        for (int i = 0; i < N_CH; i++) ctrl_d[i] = ctrl_q[i];
        irq_en_d = irq_en_q;
        done_d   = done_q;
        to_d     = to_q;
`ifdef RLBP_TIMEOUT_EN
        timeout_d = timeout_q;
`endif
        if (wr_en) begin
            for (int i = 0; i < N_CH; i++) begin
                if (offset == 8'(4*i)) ctrl_d[i] = wbs_dat_i[CTRL_W-1:0];
            end
            if (offset == OFF_IRQ_EN) irq_en_d = wbs_dat_i[2*N_CH-1:0];
            if (offset == OFF_STATUS) begin
                done_d = done_q & ~wbs_dat_i[8 +: N_CH];
                to_d   = to_q & ~wbs_dat_i[16 +: N_CH];
            end
`ifdef RLBP_TIMEOUT_EN
            if (offset == OFF_TIMEOUT) timeout_d = wbs_dat_i[TO_W-1:0];
`endif
        end
        done_d = done_d | done_set;
        to_d   = to_d | to_set;
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (offset == 8'(4*i)) rd_data[CTRL_W-1:0] = ctrl_q[i];
        end
        case (offset)
            OFF_STATUS: begin
                rd_data[N_CH-1:0]    = busy;
                rd_data[8 +: N_CH]   = done_q;
                rd_data[16 +: N_CH]  = to_q;
            end
            OFF_IRQ_EN:  rd_data[2*N_CH-1:0] = irq_en_q;
            OFF_TIMEOUT: rd_data[TO_W-1:0]   = timeout_rd;
            default: ;
        endcase
    end

    always_comb begin
        ack_d = accept;
        dat_d = (accept && !wbs_we_i) ? rd_data : '0;
        irq_d = |({to_q, done_q} & irq_en_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            irq_q    <= 1'b0;
            irq_en_q <= '0;
            done_q   <= '0;
            to_q     <= '0;
            for (int i = 0; i < N_CH; i++) begin
                ctrl_q[i]  <= '0;
                state_q[i] <= ST_IDLE;
            end
`ifdef RLBP_TIMEOUT_EN
            timeout_q <= '1;
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
`endif
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            irq_q    <= irq_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            to_q     <= to_d;
            for (int i = 0; i < N_CH; i++) begin
                ctrl_q[i]  <= ctrl_d[i];
                state_q[i] <= state_d[i];
            end
`ifdef RLBP_TIMEOUT_EN
            timeout_q <= timeout_d;
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
`endif
        end
    end

    logic unused_ok;
    assign unused_ok = ^{wbs_adr_i[27:8], wbs_sel_i[3:1], wbs_dat_i};

endmodule

// File: tb/tb_rlbp_wb_ctrl.sv
// Directed bench for rlbp_wb_ctrl: bus protocol, register map, channel FSMs, sticky status and irq.
module tb_rlbp_wb_ctrl;

    localparam int N_CH   = 2;
    localparam int CTRL_W = 12;
    localparam int TO_W   = 16;

    localparam logic [31:0] A_CTRL0   = 32'h3000_0000;
    localparam logic [31:0] A_CTRL1   = 32'h3000_0004;
    localparam logic [31:0] A_STATUS  = 32'h3000_0020;
    localparam logic [31:0] A_IRQ_EN  = 32'h3000_0024;
    localparam logic [31:0] A_CMD     = 32'h3000_0028;
    localparam logic [31:0] A_TIMEOUT = 32'h3000_002C;

`ifdef RLBP_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_RST = 32'h0000_FFFF;
`else
    localparam logic [31:0] TIMEOUT_RST = 32'h0000_0000;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                   wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]             wbs_sel_i;
    logic [31:0]            wbs_adr_i, wbs_dat_i;
    logic                   wbs_ack_o;
    logic [31:0]            wbs_dat_o;
    logic [N_CH*CTRL_W-1:0] ch_ctrl;
    logic [N_CH-1:0]        ch_start;
    logic [N_CH-1:0]        ch_done;
    logic                   irq;
    logic [2*N_CH-1:0]      dbg_state;

    rlbp_wb_ctrl #(.N_CH(N_CH), .CTRL_W(CTRL_W), .TO_W(TO_W)) dut (
        .clk(clk), .rst(rst),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .ch_ctrl(ch_ctrl), .ch_start(ch_start), .ch_done(ch_done),
        .irq(irq), .dbg_state(dbg_state)
    );

    // scoreboard
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    int          start_cnt0 = 0;
    int          start_cnt1 = 0;
    int          s0;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            start_cnt0 += int'(ch_start[0]);
            start_cnt1 += int'(ch_start[1]);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic bus_idle();
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'h0;
        wbs_adr_i = '0;
        wbs_dat_i = '0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_sel_i = sel;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
    endtask

    task automatic wb_write_sel(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        drive(1'b1, adr, dat, sel);
        cycles(1);
        check("wr_ack", 32'(wbs_ack_o), 32'd1);
        bus_idle();
        cycles(1);
        check("wr_ack_drop", 32'(wbs_ack_o), 32'd0);
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
        wb_write_sel(adr, dat, 4'hF);
    endtask

    task automatic wb_read(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        exp_q.push_back(exp);
        drive(1'b0, adr, 32'h0, 4'hF);
        cycles(1);
        check({tag, "_ack"}, 32'(wbs_ack_o), 32'd1);
        if (wbs_ack_o === 1'b1) check(tag, wbs_dat_o, exp_q.pop_front());
        bus_idle();
        cycles(1);
        check({tag, "_ack_drop"}, 32'(wbs_ack_o), 32'd0);
    endtask

    task automatic pulse_done(input logic [N_CH-1:0] v);
        ch_done = v;
        cycles(1);
        ch_done = '0;
    endtask

    initial begin
        rst = 1'b1;
        ch_done = '0;
        bus_idle();
        cycles(3);
        check("rst_ack", 32'(wbs_ack_o), 32'd0);
        check("rst_dat", wbs_dat_o, 32'd0);
        check("rst_start", 32'(ch_start), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_ctrl", 32'(ch_ctrl), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        cycles(1);

        wb_read("status_rst", A_STATUS, 32'h0);
        wb_read("irq_en_rst", A_IRQ_EN, 32'h0);
        wb_read("timeout_rst", A_TIMEOUT, TIMEOUT_RST);

        // control words
        wb_write(A_CTRL1, 32'h0000_0ABC);
        check("ch_ctrl1", 32'(ch_ctrl[23:12]), 32'hABC);
        wb_read("ctrl1", A_CTRL1, 32'h0000_0ABC);
        wb_write_sel(A_CTRL0, 32'h0000_0123, 4'hE);
        wb_read("ctrl0_sel0", A_CTRL0, 32'h0);
        wb_write(A_CTRL0, 32'hFFFF_F5A5);
        wb_read("ctrl0_trunc", A_CTRL0, 32'h0000_05A5);
        check("ch_ctrl_all", 32'(ch_ctrl), 32'h00AB_C5A5);
        wb_read("cmd_reads0", A_CMD, 32'h0);

        // continuous strobe: ack 1,0,1,0
        exp_q.push_back(32'h0000_0ABC);
        exp_q.push_back(32'h0000_0ABC);
        drive(1'b0, A_CTRL1, 32'h0, 4'hF);
        cycles(1);
        check("burst_ack1", 32'(wbs_ack_o), 32'd1);
        check("burst_dat1", wbs_dat_o, exp_q.pop_front());
        cycles(1);
        check("burst_gap", 32'(wbs_ack_o), 32'd0);
        cycles(1);
        check("burst_ack2", 32'(wbs_ack_o), 32'd1);
        check("burst_dat2", wbs_dat_o, exp_q.pop_front());
        bus_idle();
        cycles(1);
        check("burst_end", 32'(wbs_ack_o), 32'd0);

        // outside the window: never ack
        drive(1'b0, 32'h4000_0004, 32'h0, 4'hF);
        for (int i = 0; i < 3; i++) begin
            cycles(1);
            check("out_window_ack", 32'(wbs_ack_o), 32'd0);
        end
        bus_idle();
        cycles(1);

        // unmapped offsets inside the window
        wb_write(32'h3000_0010, 32'hFFFF_FFFF);
        wb_read("unmapped10", 32'h3000_0010, 32'h0);
        wb_read("unmapped30", 32'h3000_0030, 32'h0);
        wb_read("ctrl1_keep", A_CTRL1, 32'h0000_0ABC);

        // single launch + done + irq + W1C
        wb_write(A_IRQ_EN, 32'h1);
        wb_read("irq_en", A_IRQ_EN, 32'h1);
        s0 = start_cnt0;
        drive(1'b1, A_CMD, 32'h1, 4'hF);
        cycles(1);
        check("cmd_ack", 32'(wbs_ack_o), 32'd1);
        check("start_pulse", 32'(ch_start), 32'h1);
        bus_idle();
        cycles(1);
        check("start_end", 32'(ch_start), 32'h0);
        check("state_wait0", 32'(dbg_state), 32'h2);
        pulse_done(2'b10);
        wb_read("status_busy", A_STATUS, 32'h0000_0001);
        cycles(1);
        pulse_done(2'b01);
        check("irq_delay", 32'(irq), 32'd0);
        cycles(1);
        check("irq_set", 32'(irq), 32'd1);
        check("start_count", 32'(start_cnt0 - s0), 32'd1);
        wb_read("status_done", A_STATUS, 32'h0000_0100);
        wb_write(A_STATUS, 32'h0000_0100);
        check("irq_clr", 32'(irq), 32'd0);
        wb_read("status_clr", A_STATUS, 32'h0);

        // second CMD while busy is ignored
        s0 = start_cnt0;
        wb_write(A_CMD, 32'h1);
        wb_write(A_CMD, 32'h1);
        cycles(2);
        check("double_cmd", 32'(start_cnt0 - s0), 32'd1);
        wb_read("status_busy2", A_STATUS, 32'h0000_0001);
        pulse_done(2'b01);
        wb_read("status_done2", A_STATUS, 32'h0000_0100);

        // W1C coinciding with a new done: set wins
        wb_write(A_CMD, 32'h1);
        drive(1'b1, A_STATUS, 32'h0000_0100, 4'hF);
        ch_done = 2'b01;
        cycles(1);
        ch_done = '0;
        check("coinc_ack", 32'(wbs_ack_o), 32'd1);
        bus_idle();
        cycles(1);
        wb_read("status_coinc", A_STATUS, 32'h0000_0100);
        wb_write(A_STATUS, 32'h0000_0100);
        wb_read("status_clr2", A_STATUS, 32'h0);

        // reset during WAIT, with ch_done asserted inside the reset
        wb_write(A_CMD, 32'h2);
        check("state_wait1", 32'(dbg_state), 32'h8);
        rst = 1'b1;
        ch_done = 2'b10;
        cycles(2);
        rst = 1'b0;
        ch_done = '0;
        check("rst_mid_state", 32'(dbg_state), 32'h0);
        check("rst_mid_ctrl", 32'(ch_ctrl), 32'h0);
        check("rst_mid_irq", 32'(irq), 32'd0);
        wb_read("status_after_rst", A_STATUS, 32'h0);
        pulse_done(2'b10);
        wb_read("status_idle_done", A_STATUS, 32'h0);

`ifdef RLBP_TIMEOUT_EN
        wb_write(A_TIMEOUT, 32'h4);
        wb_read("timeout_rw", A_TIMEOUT, 32'h4);
        wb_write(A_IRQ_EN, 32'h8);
        wb_write(A_CMD, 32'h2);
        cycles(8);
        wb_read("status_to", A_STATUS, 32'h0002_0000);
        check("irq_to", 32'(irq), 32'd1);
        wb_write(A_STATUS, 32'h0002_0000);
        wb_read("status_to_clr", A_STATUS, 32'h0);
        // done on the last WAIT cycle wins over the timeout
        wb_write(A_CMD, 32'h1);
        cycles(3);
        pulse_done(2'b01);
        wb_read("status_done_vs_to", A_STATUS, 32'h0000_0100);
`else
        wb_write(A_TIMEOUT, 32'h4);
        wb_read("timeout_ro0", A_TIMEOUT, 32'h0);
        wb_write(A_CMD, 32'h2);
        cycles(20);
        wb_read("status_no_to", A_STATUS, 32'h0000_0002);
        pulse_done(2'b10);
        wb_read("status_done1", A_STATUS, 32'h0000_0200);
`endif

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rlbp_wb_ctrl.md
RLBP_WB_CTRL -- requirements
Module: rlbp_wb_ctrl

Interface
REQ-001 Parameter N_CH, default 2, number of independent RLBP channels, legal range 1..4.
REQ-002 Parameter CTRL_W, default 12, width of each channel control word, legal range 1..32.
REQ-003 Parameter TO_W, default 16, width of the timeout counter and TIMEOUT register.
REQ-004 clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone classic slave cycle, strobe and write-enable.
REQ-007 wbs_sel_i  input  4  byte selects; a write updates a register only when wbs_sel_i[0]=1.
REQ-008 wbs_adr_i  input  32  byte address; select = adr[31:28]==4'h3; register offset = adr[7:0].
REQ-009 wbs_dat_i  input  32  write data.
REQ-010 wbs_ack_o  output  1  transfer acknowledge.
REQ-011 wbs_dat_o  output  32  read data, valid while wbs_ack_o=1.
REQ-012 ch_ctrl  output  N_CH*CTRL_W  control word per channel; channel i occupies bits [i*CTRL_W +: CTRL_W].
REQ-013 ch_start  output  N_CH  one-cycle start pulse per channel.
REQ-014 ch_done  input  N_CH  completion pulse or level from each RLBP core, sampled on every clk edge.
REQ-015 irq  output  1  level interrupt.

Function
REQ-016 Register map: 0x00+4*i CTRL[i] (RW, i<N_CH); 0x20 STATUS (RO/W1C); 0x24 IRQ_EN (RW, [2*N_CH-1:0]); 0x28 CMD (WO, bit i launches channel i; reads 0); 0x2C TIMEOUT (RW, [TO_W-1:0]).
REQ-017 STATUS layout: [N_CH-1:0] busy, [8+N_CH-1:8] done sticky, [16+N_CH-1:16] timeout sticky; all other bits read 0.
REQ-018 A transfer is accepted when cyc&stb&select and wbs_ack_o=0; wbs_ack_o SHALL be 1 in exactly the following cycle and 0 in the cycle after that, giving one ack per two cycles under continuous strobe.
REQ-019 Unmapped offsets inside the select window SHALL ack, read 0 and ignore writes; accesses outside the window SHALL never ack.
REQ-020 Read data SHALL reflect register values in the acceptance cycle; register writes SHALL take effect on the clock edge that ends the acceptance cycle.
REQ-021 Each channel SHALL run a 3-state FSM: IDLE -> START on CMD bit i=1 -> WAIT after exactly one cycle -> IDLE.
REQ-022 ch_start[i] SHALL be 1 only while in START; busy[i] SHALL be 1 in START and WAIT.
REQ-023 A CMD bit written to a channel not in IDLE SHALL be ignored.
REQ-024 In WAIT, ch_done[i]=1 SHALL return the channel to IDLE and set done[i]; ch_done during IDLE or START SHALL be ignored.
REQ-025 Writing 1 to a STATUS sticky bit SHALL clear it; when a set and a clear coincide in the same cycle, the set SHALL win.
REQ-026 CTRL[i] writes SHALL be accepted in any state; ch_ctrl SHALL follow register contents with no additional delay.
REQ-027 irq SHALL be registered and equal |({to, done} & IRQ_EN) delayed by one cycle.

Reset
REQ-028 On rst: all CTRL=0, IRQ_EN=0, TIMEOUT={TO_W{1}}, all FSMs=IDLE, all sticky bits=0, all counters=0, wbs_ack_o=0, wbs_dat_o=0, ch_start=0, irq=0.
REQ-029 rst asserted mid-operation SHALL abort any WAIT without setting done or timeout bits.

Configuration
REQ-030 Macro RLBP_TIMEOUT_EN: when defined, a per-channel counter SHALL clear on entry to WAIT and increment each WAIT cycle; reaching TIMEOUT SHALL return the channel to IDLE and set to[i]; ch_done in that same cycle SHALL take priority and set done[i] instead.
REQ-031 Without RLBP_TIMEOUT_EN, WAIT SHALL last until ch_done, the to bits SHALL read 0, and TIMEOUT SHALL read 0 and ignore writes.

Verification
REQ-032 Write CTRL[1]=0xABC, then read it back -> ack one cycle after acceptance; rdata=0x00000ABC; ch_ctrl[23:12]=0xABC.
REQ-033 Write CMD=0x1 and pulse ch_done[0] 5 cycles later -> ch_start[0] high for exactly 1 cycle; STATUS=0x00000100 afterwards; with IRQ_EN=0x1, irq=1; writing STATUS=0x100 clears it and drops irq.
REQ-034 Write CMD=0x1 twice while busy -> only one ch_start pulse is produced.
REQ-035 With RLBP_TIMEOUT_EN and TIMEOUT=4, issue CMD=0x2 with no done -> to[1] set; STATUS=0x00020000 after WAIT.
REQ-036 Assert rst during WAIT, and separately make W1C and done coincide -> STATUS=0 after the reset; the done bit remains set after the coincidence.
